// File: rtl/imem_access_ctrl.sv
`default_nettype none
// imem_access_ctrl: shares a single-port instruction memory between fetch reads and
// loader writes, sequencing BOOT/RUN/DRAIN phases with a loader starvation guard.
module imem_access_ctrl #(
   parameter int NENTRIES = 128,
   parameter int MAX_WAIT = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        fetch_req_i,
   input  logic [31:0] fetch_addr_i,
   output logic        fetch_gnt_o,
   output logic        fetch_rvalid_o,
   output logic [31:0] fetch_rdata_o,
   output logic        fetch_err_o,
   input  logic        ld_req_i,
   input  logic [31:0] ld_addr_i,
   input  logic [31:0] ld_data_i,
   output logic        ld_gnt_o,
   output logic        ld_err_o,
   input  logic        boot_done_i,
   input  logic        reload_req_i,
   output logic        core_hold_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] mem_wdata_o,
   output logic        mem_ren_o,
   output logic        mem_wen_o,
   input  logic [31:0] mem_rdata_i
);

   typedef enum logic [1:0] {
      ST_BOOT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] wait_cnt, wait_cnt_nxt;
   logic       rd_pend, rd_err, wr_err;
   logic       fetch_ok, ld_ok, fetch_gnt, ld_gnt;

   assign fetch_ok = (fetch_addr_i[1:0] == 2'b00) && (fetch_addr_i[31:2] < 30'(NENTRIES));
   assign ld_ok    = (ld_addr_i[1:0] == 2'b00) && (ld_addr_i[31:2] < 30'(NENTRIES));

   always_comb begin
      state_nxt    = state;
      fetch_gnt    = 1'b0;
      ld_gnt       = 1'b0;
      wait_cnt_nxt = 8'd0;
      case (state)
         ST_BOOT: begin
            ld_gnt = ld_req_i;
            if (boot_done_i) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (ld_req_i && (wait_cnt == 8'(MAX_WAIT))) begin
               ld_gnt = 1'b1;
            end else begin
               fetch_gnt = fetch_req_i;
               ld_gnt    = ld_req_i & ~fetch_req_i;
            end
            // Count refused loader cycles; any grant or idle loader clears the count
            if (ld_req_i && !ld_gnt)
               wait_cnt_nxt = (wait_cnt == 8'(MAX_WAIT)) ? wait_cnt : wait_cnt + 8'd1;
            if (reload_req_i) begin
               state_nxt    = ST_DRAIN;
               wait_cnt_nxt = 8'd0;
            end
         end
         ST_DRAIN: begin
            ld_gnt = ld_req_i;
            // No fetch is granted here, so the only possible read completes this cycle
            state_nxt = ST_BOOT;
         end
         default: state_nxt = ST_BOOT;
      endcase
      if (!rst_ni) begin
         fetch_gnt = 1'b0;
         ld_gnt    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state    <= ST_BOOT;
         wait_cnt <= 8'd0;
         rd_pend  <= 1'b0;
         rd_err   <= 1'b0;
         wr_err   <= 1'b0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         rd_pend  <= fetch_gnt;
         rd_err   <= fetch_gnt & ~fetch_ok;
         wr_err   <= ld_gnt & ~ld_ok;
      end
   end

   assign fetch_gnt_o = fetch_gnt;
   assign ld_gnt_o    = ld_gnt;
   assign mem_ren_o   = fetch_gnt & fetch_ok;
   assign mem_wen_o   = ld_gnt & ld_ok;
   assign mem_addr_o  = fetch_gnt ? fetch_addr_i : (ld_gnt ? ld_addr_i : 32'd0);
   assign mem_wdata_o = ld_gnt ? ld_data_i : 32'd0;

   // Response outputs are forced quiet while reset is asserted
   assign fetch_rvalid_o = rd_pend & rst_ni;
   assign fetch_err_o    = rd_pend & rd_err & rst_ni;
   assign fetch_rdata_o  = (rd_pend && !rd_err && rst_ni) ? mem_rdata_i : 32'd0;
   assign ld_err_o       = wr_err & rst_ni;
   assign core_hold_o    = (state != ST_RUN) | ~rst_ni;

endmodule
`default_nettype wire

// File: doc/imem_access_ctrl.md
Name: imem_access_ctrl

Overview:
Sequences and arbitrates the single-port instruction memory between two requesters: the fetch unit (reads) and the program loader (writes).
- After reset the block is in a boot phase: the core is held, and only loader writes reach the memory.
- In run phase fetch has priority. A starvation counter guarantees the loader forward progress.
- Sits between the fetch unit / loader and the instruction memory read/write enables.

Parameters:
NENTRIES, 128, number of 32-bit words in the instruction memory; word index is addr[31:2].
MAX_WAIT, 8, consecutive cycles a loader request may be refused in RUN before it is forced through (1..255).

Ports:
clk_i  input  1  clock
rst_ni  input  1  synchronous reset, active low
fetch_req_i  input  1  fetch read request
fetch_addr_i  input  32  fetch byte address
fetch_gnt_o  output  1  fetch request accepted this cycle
fetch_rvalid_o  output  1  read data valid (one cycle after grant)
fetch_rdata_o  output  32  read data
fetch_err_o  output  1  qualifies fetch_rvalid_o: address misaligned or out of range
ld_req_i  input  1  loader write request
ld_addr_i  input  32  loader byte address
ld_data_i  input  32  loader write data
ld_gnt_o  output  1  loader write accepted this cycle
ld_err_o  output  1  one-cycle pulse, cycle after a granted out-of-range/misaligned write
boot_done_i  input  1  loader finished; release the core
reload_req_i  input  1  return to boot phase for reprogramming
core_hold_o  output  1  hold the core/fetch unit (1 in BOOT and DRAIN)
mem_addr_o  output  32  byte address to the instruction memory
mem_wdata_o  output  32  write data to the memory
mem_ren_o  output  1  memory read enable
mem_wen_o  output  1  memory write enable
mem_rdata_i  input  32  memory read data, valid the cycle after mem_ren_o

Behaviour:
- Reset (rst_ni=0 at a clk_i edge) forces the following:
  - state=BOOT, wait counter=0.
  - fetch_rvalid_o=0, fetch_rdata_o=0, fetch_err_o=0, ld_err_o=0.
  - core_hold_o=1.
  - All grants and memory enables are 0 while rst_ni=0.
- A request is valid if addr[1:0]==0 and addr[31:2] < NENTRIES.
- Grants, mem_addr_o, mem_wdata_o, mem_ren_o and mem_wen_o are combinational from the current state and the requests.
  - At most one grant per cycle.
  - mem_ren_o and mem_wen_o are never both 1.
- mem_ren_o / mem_wen_o assert only for a valid granted request. An invalid granted request still completes, without touching the memory.
- With nothing granted, mem_addr_o and mem_wdata_o are 0.
- Fetch read latency:
  - Grant in cycle T; fetch_rvalid_o=1 in T+1.
  - fetch_rdata_o = mem_rdata_i in T+1 when valid.
  - When invalid: fetch_rdata_o=0 and fetch_err_o=1.
  - fetch_rvalid_o is a one-cycle pulse. Back-to-back grants give back-to-back rvalid.
- A loader write completes in its grant cycle. ld_err_o pulses in T+1 if that write was invalid.
- FSM:
  - BOOT: core_hold_o=1. fetch_gnt_o=0. ld_gnt_o=ld_req_i.
    - boot_done_i=1 -> RUN next cycle. A loader write granted in that same cycle still completes.
  - RUN: core_hold_o=0. Fetch has priority: fetch_gnt_o=fetch_req_i, and ld_gnt_o=ld_req_i & ~fetch_req_i.
    - Exception: when the wait counter equals MAX_WAIT, the loader wins, fetch_gnt_o=0, and the counter clears.
    - reload_req_i=1 -> DRAIN. The fetch grant in that same cycle is still issued.
  - DRAIN: core_hold_o=1. No new fetch grants. Loader grants as in BOOT.
    - Goes to BOOT once no fetch read is outstanding (fetch_rvalid_o would be 0 next cycle), i.e. DRAIN lasts 1 cycle if a read was granted in the entry cycle, else it exits next edge.
- Wait counter (8-bit), only in RUN:
  - Increments each cycle ld_req_i=1 and ld_gnt_o=0; saturates at MAX_WAIT.
  - Clears on any loader grant, on ld_req_i=0, and on leaving RUN.
- Simultaneous boot_done_i and reload_req_i in BOOT: boot_done_i wins. reload_req_i in BOOT/DRAIN is ignored.
- Reset mid-operation: an outstanding fetch read is discarded; no rvalid is produced after reset.

Test Plan:
1. Reset, then a loader writes 0x00000013 to 0x0, 0x4, 0x8 in BOOT -> ld_gnt_o=1 each cycle, mem_wen_o=1, core_hold_o=1; fetch_req_i=1 gets no grant.
2. boot_done_i pulse, then fetch reads 0x4 with mem_rdata_i=0x00000013 -> core_hold_o=0 next cycle, fetch_gnt_o same cycle, fetch_rvalid_o=1 / rdata 0x00000013 one cycle later.
3. RUN, fetch_req_i held 1, ld_req_i held 1, MAX_WAIT=8 -> loader granted exactly once every 9 cycles, fetch on the other 8; mem_ren_o and mem_wen_o never both 1.
4. Fetch to 0x200 (index 128) and to 0x6 -> both granted, mem_ren_o=0, rvalid with rdata 0 and fetch_err_o=1; loader write to 0x200 -> mem_wen_o=0, ld_err_o=1 next cycle.
5. reload_req_i with a fetch granted in the same cycle -> that rvalid is delivered, core_hold_o=1 from the next cycle, BOOT reached, fetch_gnt_o=0 thereafter.
6. rst_ni=0 in the cycle after a fetch grant -> fetch_rvalid_o stays 0, state BOOT, counter 0.
